// File: rtl/acc_sched.sv
// acc_sched: round-robin scheduler that lets NREQ requesters share one
// W-bit accumulator. Each grant walks IDLE -> LOAD -> ACC -> ACK.
// Optional feature: define ACC_SCHED_SAT_EN to make accumulation saturate
// at 2^W-1 and raise the sticky sat flag. In the default build the
// accumulator wraps and sat is tied low.
module acc_sched #(
    parameter int NREQ = 4,
    parameter int W    = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*W-1:0]       value,
    input  logic                    clear,
    output logic [NREQ-1:0]         ack,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy,
    output logic [W-1:0]            count,
    output logic [7:0]              led,
    output logic                    sat
);
    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LOAD, ACC, ACK} state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  ptr_q, ptr_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [W-1:0]   operand_q, operand_d;
    logic [W-1:0]   count_q, count_d;
    logic [GW-1:0]  rr_idx, win_idx;
    logic           win_found;
    logic [W-1:0]   val_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign val_arr[i] = value[i*W +: W];
    end

    // Round-robin search: first requester at or after ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = GW'((int'(ptr_q) + k) % NREQ);
            if (!win_found && req[rr_idx]) begin
                win_found = 1'b1;
                win_idx   = rr_idx;
            end
        end
    end

    // Next-state logic; req is only looked at while IDLE.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        operand_d = operand_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    ptr_d   = (win_idx == GW'(NREQ-1)) ? '0 : win_idx + GW'(1);
                    state_d = LOAD;
                end
            end
            LOAD: begin
                operand_d = val_arr[grant_q];
                state_d   = ACC;
            end
            ACC:     state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef ACC_SCHED_SAT_EN
    logic         sat_q, sat_d;
    logic [W:0]   sum;

    assign sum = {1'b0, count_q} + {1'b0, operand_q};

    // Saturating accumulate; clear has the last word over the ACC update.
    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (state_q == ACC) begin
            if (sum[W]) begin
                count_d = '1;
                sat_d   = 1'b1;
            end else begin
                count_d = sum[W-1:0];
            end
        end
        if (clear) begin
            count_d = '0;
            sat_d   = 1'b0;
        end
    end

    // Sticky saturation flag.
    always_ff @(posedge CLK) begin
        if (RST) sat_q <= 1'b0;
        else     sat_q <= sat_d;
    end

    assign sat = sat_q;
`else
    // Wrapping accumulate; clear has the last word over the ACC update.
    always_comb begin
        count_d = count_q;
        if (state_q == ACC) count_d = count_q + operand_q;
        if (clear)          count_d = '0;
    end

    assign sat = 1'b0;
`endif

    // State and datapath registers; RST beats clear and req.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            grant_q   <= '0;
            operand_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            operand_q <= operand_d;
            count_q   <= count_d;
        end
    end

    assign ack      = (state_q == ACK) ? (NREQ'(1) << grant_q) : '0;
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);
    assign count    = count_q;
    assign led      = count_q[23:16];
endmodule

// File: tb/tb_acc_sched.sv
// Directed bench for acc_sched (NREQ=4, W=32).
module tb_acc_sched;
    localparam int NREQ = 4;
    localparam int W    = 32;

    logic           CLK = 1'b0;
    logic           RST;
    logic [3:0]     req;
    logic [127:0]   value;
    logic           clear;
    logic [3:0]     ack;
    logic [1:0]     grant_id;
    logic           busy;
    logic [31:0]    count;
    logic [7:0]     led;
    logic           sat;

    int vec  = 0;
    int errs = 0;

    acc_sched #(.NREQ(NREQ), .W(W)) dut (
        .CLK(CLK), .RST(RST), .req(req), .value(value), .clear(clear),
        .ack(ack), .grant_id(grant_id), .busy(busy), .count(count),
        .led(led), .sat(sat)
    );

    always #5 CLK = ~CLK;

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1; req = '0; clear = 1'b0; value = '0;
        step; step;
        RST = 1'b0;
    endtask

    task automatic set_val(input int i, input logic [31:0] v);
        value[i*32 +: 32] = v;
    endtask

    task automatic wait_ack(output int cyc, output bit got);
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            step;
            cyc++;
            if (ack !== 4'b0000) got = 1;
        end
    endtask

    task automatic run_txn(input int i, input logic [31:0] v);
        int cyc; bit got;
        set_val(i, v);
        req[i] = 1'b1;
        wait_ack(cyc, got);
        vec++;
        if (!got) begin
            errs++;
            $display("FAIL txn_timeout req%0d: no ack after %0d cycles, wanted one within 3", i, cyc);
        end
        req[i] = 1'b0;
        step;
    endtask

    task automatic test_reset;
        RST = 1'b1; req = 4'hF; clear = 1'b1; value = '1;
        step; step;
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_hold_busy: got %b want 0", busy); end
        vec++; if (ack !== 4'h0) begin errs++; $display("FAIL rst_hold_ack: got %h want 0", ack); end
        RST = 1'b0; clear = 1'b0; req = '0; value = '0;
        step;
        vec++; if (count !== 32'h0) begin errs++; $display("FAIL rst_count: got %h want 0", count); end
        vec++; if (grant_id !== 2'd0) begin errs++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
        vec++; if ({busy, sat, led} !== 10'h0) begin errs++; $display("FAIL rst_flags: busy/sat/led got %b/%b/%h want 0", busy, sat, led); end
    endtask

    task automatic test_single;
        set_val(0, 32'd5);
        req = 4'b0001;
        step;
        vec++; if (busy !== 1'b1 || grant_id !== 2'd0 || ack !== 4'h0) begin errs++; $display("FAIL single_load: busy=%b grant=%0d ack=%h want 1/0/0", busy, grant_id, ack); end
        step;
        vec++; if (ack !== 4'h0) begin errs++; $display("FAIL single_acc_ack: got %h want 0", ack); end
        step;
        vec++; if (ack !== 4'b0001) begin errs++; $display("FAIL single_ack: got %b want 0001", ack); end
        vec++; if (count !== 32'd5 || led !== 8'h00) begin errs++; $display("FAIL single_count: count=%h led=%h want 5/00", count, led); end
        req = 4'b0000;
        step;
        vec++; if (ack !== 4'h0 || busy !== 1'b0) begin errs++; $display("FAIL single_idle: ack=%h busy=%b want 0/0", ack, busy); end
    endtask

    task automatic test_round_robin;
        int cyc; bit got;
        do_reset;
        for (int i = 0; i < 4; i++) set_val(i, 32'(i + 1));
        req = 4'hF;
        for (int g = 0; g < 4; g++) begin
            wait_ack(cyc, got);
            vec++; if (ack !== (4'b0001 << g) || grant_id !== 2'(g)) begin errs++; $display("FAIL rr_grant%0d: ack=%b grant=%0d want %b/%0d", g, ack, grant_id, 4'b0001 << g, g); end
            req[g] = 1'b0;
            step;
        end
        vec++; if (count !== 32'd10) begin errs++; $display("FAIL rr_count: got %0d want 10", count); end
        req = 4'b1001;
        wait_ack(cyc, got);
        vec++; if (ack !== 4'b0001) begin errs++; $display("FAIL rr_ptr_wrapped: got %b want 0001", ack); end
        req[0] = 1'b0;
        step;
        wait_ack(cyc, got);
        vec++; if (ack !== 4'b1000) begin errs++; $display("FAIL rr_second: got %b want 1000", ack); end
        req = '0;
        step;
        vec++; if (count !== 32'd15) begin errs++; $display("FAIL rr_count2: got %0d want 15", count); end
    endtask

    task automatic test_wrap_ptr;
        int cyc; bit got;
        do_reset;
        run_txn(2, 32'd7);
        set_val(0, 32'd1);
        req = 4'b0101;
        wait_ack(cyc, got);
        vec++; if (ack !== 4'b0001) begin errs++; $display("FAIL wrap_first: got %b want 0001", ack); end
        req[0] = 1'b0;
        step;
        wait_ack(cyc, got);
        vec++; if (ack !== 4'b0100) begin errs++; $display("FAIL wrap_second: got %b want 0100", ack); end
        req = '0;
        step;
        vec++; if (count !== 32'd15) begin errs++; $display("FAIL wrap_count: got %0d want 15", count); end
    endtask

    task automatic test_ignore_midflight;
        int cyc; bit got;
        do_reset;
        set_val(0, 32'd2); set_val(1, 32'd3);
        req = 4'b0001;
        step;
        req = 4'b0011;
        step; step;
        vec++; if (ack !== 4'b0001 || grant_id !== 2'd0) begin errs++; $display("FAIL ignore_ack: ack=%b grant=%0d want 0001/0", ack, grant_id); end
        req[0] = 1'b0;
        step;
        wait_ack(cyc, got);
        vec++; if (ack !== 4'b0010) begin errs++; $display("FAIL ignore_next: got %b want 0010", ack); end
        req = '0;
        step;
        vec++; if (count !== 32'd5) begin errs++; $display("FAIL ignore_count: got %0d want 5", count); end
    endtask

    task automatic test_led_clear;
        do_reset;
        run_txn(1, 32'h00FF_FFFF);
        vec++; if (count !== 32'h00FF_FFFF || led !== 8'hFF) begin errs++; $display("FAIL led_ff: count=%h led=%h want 00ffffff/ff", count, led); end
        run_txn(1, 32'd1);
        vec++; if (count !== 32'h0100_0000 || led !== 8'h00) begin errs++; $display("FAIL led_carry: count=%h led=%h want 01000000/00", count, led); end
        set_val(1, 32'd5);
        req = 4'b0010;
        step; step;
        clear = 1'b1;
        step;
        clear = 1'b0;
        vec++; if (ack !== 4'b0010 || count !== 32'h0) begin errs++; $display("FAIL clear_in_acc: ack=%b count=%h want 0010/0", ack, count); end
        req = '0;
        step;
        vec++; if (count !== 32'h0) begin errs++; $display("FAIL clear_hold: got %h want 0", count); end
        run_txn(1, 32'd3);
        clear = 1'b1;
        step;
        clear = 1'b0;
        vec++; if (count !== 32'h0 || busy !== 1'b0) begin errs++; $display("FAIL clear_idle: count=%h busy=%b want 0/0", count, busy); end
    endtask

    task automatic test_overflow;
        logic [31:0] exp1, exp2;
        logic        exps;
`ifdef ACC_SCHED_SAT_EN
        exp1 = 32'hFFFF_FFFF; exp2 = 32'hFFFF_FFFF; exps = 1'b1;
`else
        exp1 = 32'h10; exp2 = 32'h11; exps = 1'b0;
`endif
        do_reset;
        run_txn(3, 32'hFFFF_FFF0);
        vec++; if (sat !== 1'b0) begin errs++; $display("FAIL ovf_presat: got %b want 0", sat); end
        run_txn(3, 32'h20);
        vec++; if (count !== exp1 || sat !== exps) begin errs++; $display("FAIL ovf_first: count=%h sat=%b want %h/%b", count, sat, exp1, exps); end
        run_txn(3, 32'h1);
        vec++; if (count !== exp2 || sat !== exps) begin errs++; $display("FAIL ovf_sticky: count=%h sat=%b want %h/%b", count, sat, exp2, exps); end
        clear = 1'b1;
        step;
        clear = 1'b0;
        vec++; if (count !== 32'h0 || sat !== 1'b0) begin errs++; $display("FAIL ovf_clear: count=%h sat=%b want 0/0", count, sat); end
    endtask

    task automatic test_rst_abort;
        int cyc; bit got;
        do_reset;
        run_txn(0, 32'd9);
        set_val(0, 32'd4);
        req = 4'b0001;
        step; step;
        RST = 1'b1;
        step;
        RST = 1'b0;
        vec++; if (ack !== 4'h0 || busy !== 1'b0 || count !== 32'h0) begin errs++; $display("FAIL abort_state: ack=%b busy=%b count=%h want 0/0/0", ack, busy, count); end
        wait_ack(cyc, got);
        vec++; if (ack !== 4'b0001 || cyc != 3) begin errs++; $display("FAIL abort_reissue: ack=%b cycles=%0d want 0001/3", ack, cyc); end
        req = '0;
        step;
        vec++; if (count !== 32'd4) begin errs++; $display("FAIL abort_count: got %0d want 4", count); end
    endtask

    initial begin
        RST = 1'b1; req = '0; value = '0; clear = 1'b0;
        test_reset;
        test_single;
        test_round_robin;
        test_wrap_ptr;
        test_ignore_midflight;
        test_led_clear;
        test_overflow;
        test_rst_abort;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
